mdio_phy_responder: RTL and testbench
=====================================

MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: PHY address this responder answers to.
REQ-002 SHALL have parameter PHY_ID1, default 16'h0141: read-only value of register 2.
REQ-003 SHALL have parameter PHY_ID2, default 16'h0DD1: read-only value of register 3.
REQ-004 SHALL have port clk  input  1  single system clock; all logic in this domain; frequency >= 8x MDC.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port mdc  input  1  MDIO management clock from the station-management master, asynchronous to clk.
REQ-007 SHALL have port mdio_i  input  1  MDIO pad input value.
REQ-008 SHALL have port mdio_o  output  1  MDIO pad output value.
REQ-009 SHALL have port mdio_t  output  1  tristate control: 1 = released (high-Z), 0 = driving mdio_o.
REQ-010 SHALL have port link_up  input  1  link state, asynchronous, reflected in register 1 bit 2.
REQ-011 SHALL have port wr_strobe  output  1  one-clk pulse per accepted write frame.
REQ-012 SHALL have port wr_addr  output  5  register address of the last write frame.
REQ-013 SHALL have port wr_data  output  16  data of the last write frame.
REQ-014 SHALL have port rd_strobe  output  1  one-clk pulse per accepted read frame.

Function
REQ-015 SHALL synchronise mdc, mdio_i and link_up through 2-flop synchronisers; an "MDC edge" is a clk cycle in which synced mdc goes 0->1; mdio bits are sampled only on MDC edges.
REQ-016 SHALL use states IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA with a 5-bit bit counter; the FSM advances only on MDC edges.
REQ-017 IDLE: count consecutive sampled 1s, saturating at 32; a 0 with count < 32 clears the count; a 0 with count = 32 is ST bit 1 -> ST.
REQ-018 ST: a sampled 1 -> OP; a 0 -> IDLE with count 0.
REQ-019 OP: 2 bits; "10" = read, "01" = write; "00"/"11" -> IDLE with count 0.
REQ-020 PHYAD then REGAD: 5 bits each, MSB first; on PHYAD != PHY_ADDR -> IDLE with count 0, mdio_t stays 1.
REQ-021 Let edge k = the MDC edge sampling REGAD bit 0. Read: capture the register value into the shift register and pulse rd_strobe one clk after edge k; after edge k+1 drive mdio_t=0, mdio_o=0 (TA); after edges k+2..k+17 drive data bits 15..0; after edge k+18 set mdio_t=1 -> IDLE with count 0.
REQ-022 Write: TA bits sampled at edges k+1, k+2 SHALL be "10", else -> IDLE with no write; data bits 15..0 sampled at edges k+3..k+18.
REQ-023 Write: one clk after edge k+18, update the register, load wr_addr/wr_data, pulse wr_strobe for one clk, then -> IDLE with count 0.
REQ-024 mdio_t SHALL be 0 only between REQ-021's drive and release points; at all other times mdio_t=1.
REQ-025 Register map: reg0 RW, default 16'h1140; reg1 RO = 16'h7849 with bit 2 = synced link_up; reg2 = PHY_ID1 RO; reg3 = PHY_ID2 RO; regs 4-31 RW, default 16'h0000.
REQ-026 A write to reg0 with bit 15 = 1 SHALL load 16'h1140 (self-clearing reset); writes to RO registers SHALL be discarded but still pulse wr_strobe.
REQ-027 If mdc stops mid-frame, the FSM SHALL hold its state indefinitely; there is no timeout.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, preamble count 0, mdio_t=1, mdio_o=0, wr_strobe=0, rd_strobe=0, wr_addr=0, wr_data=0, registers to their defaults.
REQ-029 rst asserted mid-frame SHALL release mdio within the same cycle; the next accepted frame requires a fresh 32-bit preamble.

Verification
REQ-030 Read reg2 at PHY_ADDR=1 after 32-bit preamble -> TA 0, then 16'h0141 on mdio, MSB first; rd_strobe pulses once.
REQ-031 Write 16'hBEEF to reg 5, then read reg 5 -> wr_strobe with wr_addr=5, wr_data=16'hBEEF; readback 16'hBEEF.
REQ-032 Write 16'h8000 to reg0, then read reg0 -> reads 16'h1140.
REQ-033 Read with PHYAD=2 -> mdio_t stays 1 throughout; no strobes.
REQ-034 Preamble of 31 ones then ST -> ignored; link_up 0->1, then read reg1 -> 16'h784D.
REQ-035 Assert rst during RDATA bit 8 -> mdio_t=1 immediately; the next full frame completes correctly.

Source files
------------

// File: rtl/mdio_phy_responder.sv
`default_nettype none
// ============================================================================
// Module      : mdio_phy_responder
// Description : Clause-22 MDIO slave. It oversamples MDC/MDIO in the clk
//               domain, decodes read/write frames addressed to PHY_ADDR and
//               serves a 32 x 16-bit register file (regs 1-3 read-only).
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0DD1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        link_up,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_strobe
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_RDATA = 3'd6,
        S_WDATA = 3'd7
    } state_t;

    localparam logic [15:0] REG0_DEFAULT = 16'h1140;
    localparam logic [15:0] REG1_BASE    = 16'h7849;

    // Synchroniser chains and the delayed MDC copy used for edge detection
    logic [1:0]  mdc_sync_q, mdio_sync_q, link_sync_q;
    logic        mdc_prev_q;

    state_t      state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;      // preamble ones, saturates at 32
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        op_bit_q, op_bit_d;        // first opcode bit
    logic        is_read_q, is_read_d;
    logic [4:0]  addr_q, addr_d;            // PHYAD, then REGAD
    logic [15:0] shift_q, shift_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_t_q, mdio_t_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] regs_q [32];
    logic [15:0] regs_d [32];

    logic        mdc_edge;
    logic        mdio_bit;
    logic [4:0]  rd_addr;
    logic [15:0] rd_val;

    assign mdc_edge = mdc_sync_q[1] & ~mdc_prev_q;
    assign mdio_bit = mdio_sync_q[1];
    // The read address completes on the same edge that samples REGAD bit 0
    assign rd_addr  = {addr_q[3:0], mdio_bit};

    // Register-file read mux with the read-only identity/status overlays
    always_comb begin
        rd_val = regs_q[rd_addr];
        case (rd_addr)
            5'd1:    rd_val = REG1_BASE | {13'd0, link_sync_q[1], 2'b00};
            5'd2:    rd_val = PHY_ID1;
            5'd3:    rd_val = PHY_ID2;
            default: rd_val = regs_q[rd_addr];
        endcase
    end

    // Frame decoder: advances only on synchronised MDC rising edges
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        op_bit_d    = op_bit_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        mdio_o_d    = mdio_o_q;
        mdio_t_d    = mdio_t_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        if (mdc_edge) begin
            case (state_q)
                S_IDLE: begin
                    if (mdio_bit) begin
                        if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else begin
                        if (pre_cnt_q == 6'd32) state_d = S_ST;
                        pre_cnt_d = 6'd0;
                    end
                end
                S_ST: begin
                    if (mdio_bit) begin
                        state_d   = S_OP;
                        bit_cnt_d = 5'd0;
                    end else begin
                        state_d   = S_IDLE;
                        pre_cnt_d = 6'd0;
                    end
                end
                S_OP: begin
                    if (bit_cnt_q == 5'd0) begin
                        op_bit_d  = mdio_bit;
                        bit_cnt_d = 5'd1;
                    end else if (op_bit_q != mdio_bit) begin
                        is_read_d = op_bit_q;   // "10" read, "01" write
                        state_d   = S_PHYAD;
                        bit_cnt_d = 5'd0;
                        addr_d    = 5'd0;
                    end else begin
                        state_d   = S_IDLE;
                        pre_cnt_d = 6'd0;
                    end
                end
                S_PHYAD: begin
                    addr_d = {addr_q[3:0], mdio_bit};
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = 5'd0;
                        if (addr_d == PHY_ADDR) begin
                            state_d = S_REGAD;
                        end else begin
                            state_d   = S_IDLE;
                            pre_cnt_d = 6'd0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_REGAD: begin
                    addr_d = rd_addr;
                    if (bit_cnt_q == 5'd4) begin
                        state_d   = S_TA;
                        bit_cnt_d = 5'd0;
                        if (is_read_q) begin
                            shift_d     = rd_val;
                            rd_strobe_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_TA: begin
                    if (is_read_q) begin
                        if (bit_cnt_q == 5'd0) begin
                            mdio_t_d  = 1'b0;
                            mdio_o_d  = 1'b0;
                            bit_cnt_d = 5'd1;
                        end else begin
                            mdio_o_d  = shift_q[15];
                            shift_d   = {shift_q[14:0], 1'b0};
                            state_d   = S_RDATA;
                            bit_cnt_d = 5'd1;
                        end
                    end else if (bit_cnt_q == 5'd0 && mdio_bit) begin
                        bit_cnt_d = 5'd1;
                    end else if (bit_cnt_q == 5'd1 && !mdio_bit) begin
                        state_d   = S_WDATA;
                        bit_cnt_d = 5'd0;
                    end else begin
                        state_d   = S_IDLE;
                        pre_cnt_d = 6'd0;
                    end
                end
                S_RDATA: begin
                    if (bit_cnt_q == 5'd16) begin
                        mdio_t_d  = 1'b1;
                        mdio_o_d  = 1'b0;
                        state_d   = S_IDLE;
                        pre_cnt_d = 6'd0;
                    end else begin
                        mdio_o_d  = shift_q[15];
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_WDATA: begin
                    shift_d = {shift_q[14:0], mdio_bit};
                    if (bit_cnt_q == 5'd15) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = shift_d;
                        case (addr_q)
                            5'd0:    regs_d[0] = shift_d[15] ? REG0_DEFAULT : shift_d;
                            5'd1, 5'd2, 5'd3: ;  // read-only, strobe only
                            default: regs_d[addr_q] = shift_d;
                        endcase
                        state_d   = S_IDLE;
                        pre_cnt_d = 6'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    pre_cnt_d = 6'd0;
                end
            endcase
        end
    end

    // All state registers; reset releases the pad immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_sync_q  <= 2'b00;
            mdio_sync_q <= 2'b00;
            link_sync_q <= 2'b00;
            mdc_prev_q  <= 1'b0;
            state_q     <= S_IDLE;
            pre_cnt_q   <= 6'd0;
            bit_cnt_q   <= 5'd0;
            op_bit_q    <= 1'b0;
            is_read_q   <= 1'b0;
            addr_q      <= 5'd0;
            shift_q     <= 16'd0;
            mdio_o_q    <= 1'b0;
            mdio_t_q    <= 1'b1;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 16'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 0) ? REG0_DEFAULT : 16'h0000;
            end
        end else begin
            mdc_sync_q  <= {mdc_sync_q[0], mdc};
            mdio_sync_q <= {mdio_sync_q[0], mdio_i};
            link_sync_q <= {link_sync_q[0], link_up};
            mdc_prev_q  <= mdc_sync_q[1];
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            op_bit_q    <= op_bit_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_t    = mdio_t_q;
    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_phy_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_phy_responder
// Description : Self-checking bench for mdio_phy_responder. A bus-level master
//               drives whole MDIO frames; expectations come from a register
//               map model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_phy_responder;

    localparam logic [4:0]  PHY_ADDR = 5'd1;
    localparam logic [15:0] PHY_ID1  = 16'h0141;
    localparam logic [15:0] PHY_ID2  = 16'h0DD1;
    localparam int          HALF     = 8;     // clk cycles per MDC half period

    logic        clk = 1'b0;
    logic        rst, mdc, mdio_i, link_up;
    logic        mdio_o, mdio_t, wr_strobe, rd_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int errors = 0;
    int checks = 0;

    // Strobe / drive-window monitor
    int          rd_pulses, wr_pulses, t_low;
    logic [4:0]  last_wr_addr;
    logic [15:0] last_wr_data;

    // Register map model
    logic [15:0] mregs [32];

    mdio_phy_responder #(
        .PHY_ADDR (PHY_ADDR),
        .PHY_ID1  (PHY_ID1),
        .PHY_ID2  (PHY_ID2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_t    (mdio_t),
        .link_up   (link_up),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_strobe) rd_pulses++;
        if (wr_strobe) begin
            wr_pulses++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (!mdio_t) t_low++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = (i == 0) ? 16'h1140 : 16'h0000;
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        case (a)
            5'd1:    return link_up ? 16'h784D : 16'h7849;
            5'd2:    return PHY_ID1;
            5'd3:    return PHY_ID2;
            default: return mregs[a];
        endcase
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0)     mregs[0] = d[15] ? 16'h1140 : d;
        else if (a > 5'd3) mregs[a] = d;
    endtask

    // One MDC period: present the bit, raise MDC, sample the pad late in high phase
    task automatic mdc_bit(input logic b, output logic t_s, output logic o_s);
        mdio_i = b;
        repeat (HALF) @(posedge clk);
        #1 mdc = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        t_s = mdio_t;
        o_s = mdio_o;
        mdc = 1'b0;
    endtask

    // Full frame from the master's point of view, checked against the model
    task automatic do_frame(input string tag, input int pre_len, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] wdata);
        logic [13:0] hdr;
        logic        t_s, o_s, hdr_ok, rd_op, accepted;
        logic        tv [1:18];
        logic        ov [1:18];
        logic [15:0] word, exp_rd;
        rd_op    = (op == 2'b10);
        accepted = (pre_len >= 32) && (phy == PHY_ADDR) && (op == 2'b10 || op == 2'b01);
        exp_rd   = model_read(regad);
        rd_pulses = 0; wr_pulses = 0; t_low = 0;
        hdr_ok   = 1'b1;
        hdr      = {2'b01, op, phy, regad};
        for (int i = 0; i < pre_len; i++) begin
            mdc_bit(1'b1, t_s, o_s);
            hdr_ok &= t_s;
        end
        for (int i = 13; i >= 0; i--) begin
            mdc_bit(hdr[i], t_s, o_s);
            hdr_ok &= t_s;
        end
        for (int j = 1; j <= 18; j++) begin
            if (rd_op || j == 1) mdc_bit(1'b1, t_s, o_s);
            else if (j == 2)     mdc_bit(1'b0, t_s, o_s);
            else                 mdc_bit(wdata[18-j], t_s, o_s);
            tv[j] = t_s;
            ov[j] = o_s;
        end
        word = '0;
        for (int j = 2; j <= 17; j++) word[17-j] = ov[j];
        check_eq({tag, "_hdr_released"}, {31'd0, hdr_ok}, 32'd1);
        if (accepted && rd_op) begin
            check_eq({tag, "_ta"}, {30'd0, tv[1], ov[1]}, 32'd0);
            check_eq({tag, "_rdata"}, {16'd0, word}, {16'd0, exp_rd});
            check_eq({tag, "_release"}, {31'd0, tv[18]}, 32'd1);
            check_eq({tag, "_drive_cycles"}, t_low, 17 * 2 * HALF);
            check_eq({tag, "_rd_pulses"}, rd_pulses, 1);
            check_eq({tag, "_wr_pulses"}, wr_pulses, 0);
        end else if (accepted) begin
            check_eq({tag, "_wr_pulses"}, wr_pulses, 1);
            check_eq({tag, "_wr_addr"}, {27'd0, last_wr_addr}, {27'd0, regad});
            check_eq({tag, "_wr_data"}, {16'd0, last_wr_data}, {16'd0, wdata});
            check_eq({tag, "_rd_pulses"}, rd_pulses, 0);
            check_eq({tag, "_drive_cycles"}, t_low, 0);
            model_write(regad, wdata);
        end else begin
            check_eq({tag, "_rd_pulses"}, rd_pulses, 0);
            check_eq({tag, "_wr_pulses"}, wr_pulses, 0);
            check_eq({tag, "_drive_cycles"}, t_low, 0);
        end
    endtask

    // Read frame interrupted by reset while data bit 8 is on the pad
    task automatic do_abort_read(input logic [4:0] regad);
        logic [13:0] hdr;
        logic        t_s, o_s;
        hdr = {2'b01, 2'b10, PHY_ADDR, regad};
        for (int i = 0; i < 32; i++) mdc_bit(1'b1, t_s, o_s);
        for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], t_s, o_s);
        for (int j = 1; j <= 8; j++) mdc_bit(1'b1, t_s, o_s);
        mdio_i = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 mdc = 1'b1;
        repeat (HALF - 2) @(posedge clk);
        #1;
        check_eq("abort_driving_before_rst", {31'd0, mdio_t}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("abort_released_by_rst", {31'd0, mdio_t}, 32'd1);
        repeat (3) @(posedge clk);
        #1 mdc = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [1:0]  op;
        logic [4:0]  phy, ra;
        logic [15:0] d;
        rst = 1'b1; mdc = 1'b0; mdio_i = 1'b1; link_up = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
        check_eq("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
        check_eq("rst_strobes", {30'd0, wr_strobe, rd_strobe}, 32'd0);
        check_eq("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check_eq("rst_wr_data", {16'd0, wr_data}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        do_frame("rd_id1", 32, 2'b10, PHY_ADDR, 5'd2, 16'h0000);
        do_frame("wr_r5", 32, 2'b01, PHY_ADDR, 5'd5, 16'hBEEF);
        do_frame("rd_r5", 32, 2'b10, PHY_ADDR, 5'd5, 16'h0000);
        do_frame("wr_r0_reset", 32, 2'b01, PHY_ADDR, 5'd0, 16'h8000);
        do_frame("rd_r0", 32, 2'b10, PHY_ADDR, 5'd0, 16'h0000);
        do_frame("rd_phy2", 32, 2'b10, 5'd2, 5'd2, 16'h0000);
        do_frame("rd_id2", 32, 2'b10, PHY_ADDR, 5'd3, 16'h0000);
        do_frame("short_pre", 31, 2'b10, PHY_ADDR, 5'd2, 16'h0000);
        do_frame("rd_r1_down", 32, 2'b10, PHY_ADDR, 5'd1, 16'h0000);
        link_up = 1'b1;
        repeat (6) @(posedge clk);
        do_frame("rd_r1_up", 32, 2'b10, PHY_ADDR, 5'd1, 16'h0000);
        do_frame("wr_ro_r2", 32, 2'b01, PHY_ADDR, 5'd2, 16'h1234);
        do_frame("rd_r2_kept", 32, 2'b10, PHY_ADDR, 5'd2, 16'h0000);
        do_frame("bad_op", 32, 2'b11, PHY_ADDR, 5'd4, 16'h0000);

        do_abort_read(5'd5);
        do_frame("rd_after_rst", 32, 2'b10, PHY_ADDR, 5'd5, 16'h0000);
        do_frame("rd_r0_after_rst", 32, 2'b10, PHY_ADDR, 5'd0, 16'h0000);

        for (int n = 0; n < 20; n++) begin
            op  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY_ADDR;
            ra  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            d   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                link_up = ~link_up;
                repeat (6) @(posedge clk);
            end
            do_frame($sformatf("rnd%0d", n), 32, op, phy, ra, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
